seg7_scan_display: RTL and testbench

Parametrised multi-digit seven-segment display controller with its own storage and automatic scan. Digits are written at full CLK rate through an addressed write port, held in a per-digit register file, and time-multiplexed onto shared segment lines by an internal prescaler and scan counter. It replaces manual digit selection and the external down-clock in the board top level; display refresh runs independently of writes.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_scan_display_hex2seg7.sv | 19 +
 rtl/seg7_scan_display.sv | 98 +++++++++
 tb/tb_seg7_scan_display.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan display.
package seg7_pkg;

    // All segments off, including DP (outputs are active-low).
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // One stored digit: hex value, decimal point, and written-since-clear flag.
    typedef struct packed {
        logic [3:0] val;
        logic       dp;
        logic       valid;
    } digit_t;

    // Active-low {A,B,C,D,E,F,G} patterns for hex 0..F.
    localparam logic [6:0] SEG7_PATTERNS [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/seg7_scan_display_hex2seg7.sv
// Hex digit to active-low {A..G,DP} decoder. Invalid digits decode to blank.
module hex2seg7
    import seg7_pkg::*;
(
    input  logic [3:0] val_i,
    input  logic       dp_i,
    input  logic       valid_i,
    output logic [7:0] seg_o
);

    // Look up the segment pattern; a never-written digit stays dark.
    always_comb begin
        seg_o = SEG_BLANK;
        if (valid_i) begin
            seg_o = {SEG7_PATTERNS[val_i], ~dp_i};
        end
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Multi-digit seven-segment controller: addressed digit storage plus a
// free-running prescaler/scan counter that multiplexes the digits onto shared
// segment lines. Segment and anode outputs are registered together so they
// always refer to the same digit.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int SCAN_DIV = 100000
) (
    input  logic                        CLK,
    input  logic                        rst,
    input  logic                        wr,
    input  logic [$clog2(N_DIGITS)-1:0] waddr,
    input  logic [3:0]                  wdata,
    input  logic                        wdp,
    input  logic                        clr,
    output logic [7:0]                  out8_7Seg,
    output logic [N_DIGITS-1:0]         out_Anodes
);

    localparam int AW = $clog2(N_DIGITS);
    localparam int PW = $clog2(SCAN_DIV);

    localparam logic [AW:0]   NDIG      = (AW+1)'(N_DIGITS);
    localparam logic [AW-1:0] IDX_MAX   = AW'(N_DIGITS - 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

    digit_t                digits_q [N_DIGITS];
    digit_t                digits_d [N_DIGITS];
    logic [PW-1:0]         presc_q, presc_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [7:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  tick;
    digit_t                cur;

    // Register-file update: clear wins over a same-cycle write; out-of-range
    // addresses are dropped rather than aliased onto a real digit.
    always_comb begin
        digits_d = digits_q;
        if (clr) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                digits_d[i] = '0;
            end
        end else if (wr && ({1'b0, waddr} < NDIG)) begin
            digits_d[waddr] = '{val: wdata, dp: wdp, valid: 1'b1};
        end
    end

    // Prescaler wrap produces the tick that steps the scan index.
    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
    end

    assign cur = digits_q[idx_q];

    hex2seg7 u_hex2seg7 (
        .val_i   (cur.val),
        .dp_i    (cur.dp),
        .valid_i (cur.valid),
        .seg_o   (seg_d)
    );

    // Anode for the current index, one-hot-low.
    always_comb begin
        an_d = ~(AN_ONE << idx_q);
    end

    // State and output registers; reset darkens the display immediately.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                digits_q[i] <= '0;
            end
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= '1;
        end else begin
            digits_q <= digits_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign out8_7Seg  = seg_q;
    assign out_Anodes = an_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display: a directed vector table on an
// 8-digit/4-cycle instance, reset and small-configuration sequences, and
// randomized writes checked against a behavioural display model.
module tb_seg7_scan_display;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // 8 digits, 4 cycles per slot
    logic       rst8, wr8, wdp8, clr8;
    logic [2:0] waddr8;
    logic [3:0] wdata8;
    logic [7:0] seg8, an8;

    // 4 digits, 2 cycles per slot
    logic       rst4, wr4, wdp4, clr4;
    logic [1:0] waddr4;
    logic [3:0] wdata4;
    logic [7:0] seg4;
    logic [3:0] an4;

    // 6 digits, 2 cycles per slot: the 3-bit address can carry 6 and 7
    logic       rst6, wr6, wdp6, clr6;
    logic [2:0] waddr6;
    logic [3:0] wdata6;
    logic [7:0] seg6;
    logic [5:0] an6;

    seg7_scan_display #(.N_DIGITS(8), .SCAN_DIV(4)) dut8 (
        .CLK(CLK), .rst(rst8), .wr(wr8), .waddr(waddr8), .wdata(wdata8),
        .wdp(wdp8), .clr(clr8), .out8_7Seg(seg8), .out_Anodes(an8));

    seg7_scan_display #(.N_DIGITS(4), .SCAN_DIV(2)) dut4 (
        .CLK(CLK), .rst(rst4), .wr(wr4), .waddr(waddr4), .wdata(wdata4),
        .wdp(wdp4), .clr(clr4), .out8_7Seg(seg4), .out_Anodes(an4));

    seg7_scan_display #(.N_DIGITS(6), .SCAN_DIV(2)) dut6 (
        .CLK(CLK), .rst(rst6), .wr(wr6), .waddr(waddr6), .wdata(wdata6),
        .wdp(wdp6), .clr(clr6), .out8_7Seg(seg6), .out_Anodes(an6));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Hex patterns with DP dark; a lit DP clears bit 0.
    logic [7:0] hex_pat [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    logic [3:0] m_val [16];
    logic       m_dp  [16];
    logic       m_vld [16];
    int         m_n;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_val[i] = '0; m_dp[i] = 1'b0; m_vld[i] = 1'b0;
        end
        m_n = 0;
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] v, input logic dp, input logic vld);
        if (!vld) return 8'hFF;
        return dp ? (hex_pat[v] & 8'hFE) : hex_pat[v];
    endfunction

    // Expected outputs after the next edge, then that edge's storage effect.
    task automatic model_step(input int nd, input int sd, input logic w, input int addr,
                              input logic [3:0] d, input logic p, input logic c,
                              output logic [7:0] es, output logic [15:0] ea);
        int dig;
        logic [15:0] mask;
        dig  = (m_n / sd) % nd;
        mask = (16'h1 << nd) - 16'h1;
        es   = seg_of(m_val[dig], m_dp[dig], m_vld[dig]);
        ea   = mask & ~(16'h1 << dig);
        if (c) begin
            for (int i = 0; i < 16; i++) begin
                m_val[i] = '0; m_dp[i] = 1'b0; m_vld[i] = 1'b0;
            end
        end else if (w && addr < nd) begin
            m_val[addr] = d; m_dp[addr] = p; m_vld[addr] = 1'b1;
        end
        m_n++;
    endtask

    // ---------------- drivers ----------------
    task automatic cyc8(input logic w, input logic [2:0] a, input logic [3:0] d,
                        input logic p, input logic c);
        wr8 = w; waddr8 = a; wdata8 = d; wdp8 = p; clr8 = c;
        @(posedge CLK); #1;
    endtask

    task automatic cyc6(input logic w, input logic [2:0] a, input logic [3:0] d,
                        input logic p, input logic c);
        wr6 = w; waddr6 = a; wdata6 = d; wdp6 = p; clr6 = c;
        @(posedge CLK); #1;
    endtask

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [3:0] data;
        logic       dp;
        logic       clr;
        logic [7:0] eseg;
        logic [7:0] ean;
    } vec_t;

    vec_t tbl[$];
    logic [3:0] an4_exp [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [7:0]  es;
        logic [15:0] ea;
        int k;

        // Entries are one edge each, numbered from the first edge after release.
        for (int i = 0; i < 32; i++)                                  // edges 1..32: empty frame
            tbl.push_back('{1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 8'hFF, ~(8'h01 << (i / 4))});
        tbl.push_back('{1'b1, 3'd0, 4'h0, 1'b0, 1'b0, 8'hFF, 8'hFE}); // 33 write d0=0
        tbl.push_back('{1'b1, 3'd1, 4'h1, 1'b0, 1'b0, 8'h03, 8'hFE}); // 34 write d1=1
        tbl.push_back('{1'b1, 3'd2, 4'h8, 1'b1, 1'b0, 8'h03, 8'hFE}); // 35 write d2=8.
        tbl.push_back('{1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 8'h03, 8'hFE}); // 36
        for (int i = 0; i < 4; i++)                                   // 37..40
            tbl.push_back('{1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 8'h9F, 8'hFD});
        for (int i = 0; i < 4; i++)                                   // 41..44
            tbl.push_back('{1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 8'h00, 8'hFB});
        for (int i = 0; i < 20; i++)                                  // 45..64
            tbl.push_back('{1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 8'hFF, ~(8'h08 << (i / 4))});
        tbl.push_back('{1'b1, 3'd0, 4'hF, 1'b0, 1'b0, 8'h03, 8'hFE}); // 65 write d0=F while shown
        for (int i = 0; i < 3; i++)                                   // 66..68 new pattern
            tbl.push_back('{1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 8'h71, 8'hFE});
        tbl.push_back('{1'b1, 3'd3, 4'h5, 1'b0, 1'b1, 8'h9F, 8'hFD}); // 69 wr+clr together
        for (int i = 0; i < 3; i++)                                   // 70..72
            tbl.push_back('{1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 8'hFF, 8'hFD});
        for (int i = 0; i < 4; i++)                                   // 73..76
            tbl.push_back('{1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 8'hFF, 8'hFB});
        for (int i = 0; i < 4; i++)                                   // 77..80 digit 3 blank
            tbl.push_back('{1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 8'hFF, 8'hF7});

        wr8 = 0; waddr8 = 0; wdata8 = 0; wdp8 = 0; clr8 = 0;
        wr4 = 0; waddr4 = 0; wdata4 = 0; wdp4 = 0; clr4 = 0;
        wr6 = 0; waddr6 = 0; wdata6 = 0; wdp6 = 0; clr6 = 0;
        rst8 = 1; rst4 = 1; rst6 = 1;
        #1;
        rst8 = 0; rst4 = 0; rst6 = 0;
        #20;
        check("reset_seg8", seg8, 8'hFF);
        check("reset_an8",  an8,  8'hFF);
        check("reset_an4",  an4,  4'hF);
        check("reset_an6",  an6,  6'h3F);

        @(negedge CLK);
        rst8 = 1;
        #1;
        check("release_seg8", seg8, 8'hFF);
        check("release_an8",  an8,  8'hFF);

        foreach (tbl[i]) begin
            cyc8(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].dp, tbl[i].clr);
            check($sformatf("tbl%0d_seg", i + 1), seg8, tbl[i].eseg);
            check($sformatf("tbl%0d_an",  i + 1), an8,  tbl[i].ean);
        end

        // Asynchronous reset while digit 2 is displayed.
        k = 0;
        while (an8 !== 8'hFB && k < 64) begin
            cyc8(0, 0, 0, 0, 0);
            k++;
        end
        check("wait_fb", an8, 8'hFB);
        cyc8(0, 0, 0, 0, 0);
        #2;
        rst8 = 0;
        #1;
        check("async_rst_seg", seg8, 8'hFF);
        check("async_rst_an",  an8,  8'hFF);
        @(posedge CLK); @(posedge CLK); #1;
        check("held_rst_an", an8, 8'hFF);
        @(negedge CLK);
        rst8 = 1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            model_step(8, 4, 0, 0, 0, 0, 0, es, ea);
            cyc8(0, 0, 0, 0, 0);
            check($sformatf("post_rst%0d_an", i), an8, (i < 4) ? 8'hFE : 8'hFD);
            check($sformatf("post_rst%0d_seg", i), seg8, 8'hFF);
        end

        // Random traffic on the 8-digit instance against the model.
        for (int i = 0; i < 300; i++) begin
            logic w, p, c;
            logic [2:0] a;
            logic [3:0] d;
            w = 1'($urandom_range(0, 1));
            a = 3'($urandom_range(0, 7));
            d = 4'($urandom);
            p = 1'($urandom);
            c = ($urandom_range(0, 24) == 0);
            model_step(8, 4, w, int'(a), d, p, c, es, ea);
            cyc8(w, a, d, p, c);
            check($sformatf("rnd8_%0d_seg", i), seg8, es);
            check($sformatf("rnd8_%0d_an", i),  an8,  ea);
        end

        // 4-digit, 2-cycle configuration: E,D,B,7 then wrap to E.
        @(negedge CLK);
        rst4 = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            check($sformatf("n4_%0d_an", i),  an4,  an4_exp[(i / 2) % 4]);
            check($sformatf("n4_%0d_seg", i), seg4, 8'hFF);
        end

        // 6-digit instance: addresses 6 and 7 must be ignored.
        @(negedge CLK);
        rst6 = 1;
        model_reset();
        model_step(6, 2, 1, 7, 4'h8, 1'b1, 0, es, ea);
        cyc6(1, 3'd7, 4'h8, 1'b1, 0);
        check("oor7_seg", seg6, es);
        for (int i = 0; i < 12; i++) begin
            model_step(6, 2, 0, 0, 0, 0, 0, es, ea);
            cyc6(0, 0, 0, 0, 0);
            check($sformatf("oor_frame%0d_seg", i), seg6, 8'hFF);
            check($sformatf("oor_frame%0d_an", i),  an6,  ea);
        end
        for (int i = 0; i < 200; i++) begin
            logic w, p, c;
            logic [2:0] a;
            logic [3:0] d;
            w = 1'($urandom_range(0, 1));
            a = 3'($urandom_range(0, 7));
            d = 4'($urandom);
            p = 1'($urandom);
            c = ($urandom_range(0, 24) == 0);
            model_step(6, 2, w, int'(a), d, p, c, es, ea);
            cyc6(w, a, d, p, c);
            check($sformatf("rnd6_%0d_seg", i), seg6, es);
            check($sformatf("rnd6_%0d_an", i),  an6,  ea);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
